// File: rtl/ddr_line_cache_if.sv
// Purpose: CPU word port plus DDR line-controller port of the line cache, as one bundle.
// Latency: none; wires only.
// Backpressure: CPU side holds cpu_en until cpu_rdy; DDR side paced by ram_en/ram_rdy.
interface ddr_line_cache_if;
    logic         cpu_en;
    logic         cpu_write;
    logic [29:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_wmask;
    logic [31:0]  cpu_rdata;
    logic         cpu_rdy;
    logic         ram_en;
    logic         ram_write;
    logic [29:0]  ram_addr;
    logic [255:0] data_to_ram;
    logic [255:0] data_from_ram;
    logic         ram_rdy;

    // Cache side: serves the CPU, masters the DDR controller.
    modport slave (
        input  cpu_en, cpu_write, cpu_addr, cpu_wdata, cpu_wmask,
        output cpu_rdata, cpu_rdy,
        output ram_en, ram_write, ram_addr, data_to_ram,
        input  data_from_ram, ram_rdy
    );

    // Environment side: CPU requester and DDR controller.
    modport master (
        output cpu_en, cpu_write, cpu_addr, cpu_wdata, cpu_wmask,
        input  cpu_rdata, cpu_rdy,
        input  ram_en, ram_write, ram_addr, data_to_ram,
        output data_from_ram, ram_rdy
    );
endinterface

// File: rtl/ddr_line_cache.sv
// Purpose: direct-mapped write-back, write-allocate cache of 256-bit lines over a DDR line port.
// Latency: hit -> cpu_rdy one cycle after sampling; miss -> one cycle after the last line transaction.
// Backpressure: CPU holds cpu_en until the cpu_rdy pulse; DDR done needs a ram_rdy low then high.
module ddr_line_cache #(
    parameter int LINES = 4
) (
    input  logic             clk,
    input  logic             rst,
    ddr_line_cache_if.slave  bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

    state_t             state_q, state_d;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [255:0]       data_q [LINES];

    logic               ram_en_q;
    logic               ram_write_q;
    logic [29:0]        ram_addr_q;
    logic [255:0]       data_to_ram_q;
    logic               cpu_rdy_q;
    logic [31:0]        cpu_rdata_q;
    logic               busy_seen_q;

    // Request held for the duration of a miss, so a dropped cpu_en cannot disturb it.
    logic               req_write_q;
    logic [2:0]         req_word_q;
    logic [IDX_W-1:0]   req_idx_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [31:0]        req_wdata_q;
    logic [3:0]         req_wmask_q;

    logic [2:0]         in_word;
    logic [IDX_W-1:0]   in_idx;
    logic [TAG_W-1:0]   in_tag;
    logic               accept;
    logic               hit;
    logic               victim_dirty;
    logic               done;
    logic               hit_acc;
    logic               start_wb;
    logic               start_fill;
    logic               wb_done;
    logic               fill_done;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [255:0]       fill_line;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    assign in_word      = bus.cpu_addr[2:0];
    assign in_idx       = bus.cpu_addr[2+IDX_W:3];
    assign in_tag       = bus.cpu_addr[29:3+IDX_W];
    // cpu_rdy is always low in IDLE, but the term keeps the acceptance rule explicit.
    assign accept       = (state_q == IDLE) && bus.cpu_en && !cpu_rdy_q;
    assign hit          = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign victim_dirty = valid_q[in_idx] && dirty_q[in_idx];
    // A stale ready at ram_en rise must not count: a low has to be seen first.
    assign done         = ram_en_q && busy_seen_q && bus.ram_rdy;
    assign wb_done      = (state_q == WB) && done;
    assign fill_done    = (state_q == FILL) && done;

    // Fill target comes straight from the CPU on a clean miss, else from the held request.
    assign fill_idx     = (state_q == IDLE) ? in_idx : req_idx_q;
    assign fill_tag     = (state_q == IDLE) ? in_tag : req_tag_q;

    // Incoming line with any pending write already merged in.
    always_comb begin
        fill_line = bus.data_from_ram;
        if (req_write_q) begin
            fill_line[{req_word_q, 5'b0} +: 32] =
                merge_word(bus.data_from_ram[{req_word_q, 5'b0} +: 32], req_wdata_q, req_wmask_q);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and one-cycle control strobes.
    always_comb begin
        state_d    = state_q;
        hit_acc    = 1'b0;
        start_wb   = 1'b0;
        start_fill = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit) begin
                        hit_acc = 1'b1;
                        state_d = RESP;
                    end else if (victim_dirty) begin
                        start_wb = 1'b1;
                        state_d  = WB;
                    end else begin
                        start_fill = 1'b1;
                        state_d    = FILL;
                    end
                end
            end
            WB: begin
                if (done) state_d = FILL;
            end
            FILL: begin
                // ram_en is low here only right after a writeback: that is the mandatory gap cycle.
                if (!ram_en_q)  start_fill = 1'b1;
                else if (done)  state_d    = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers, DDR port, CPU response and per-line valid/dirty bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en_q      <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_addr_q    <= '0;
            data_to_ram_q <= '0;
            cpu_rdy_q     <= 1'b0;
            cpu_rdata_q   <= '0;
            busy_seen_q   <= 1'b0;
            valid_q       <= '0;
            dirty_q       <= '0;
            req_write_q   <= 1'b0;
            req_word_q    <= '0;
            req_idx_q     <= '0;
            req_tag_q     <= '0;
            req_wdata_q   <= '0;
            req_wmask_q   <= '0;
        end else begin
            cpu_rdy_q <= hit_acc || fill_done;

            if (start_wb || start_fill)         busy_seen_q <= 1'b0;
            else if (ram_en_q && !bus.ram_rdy)  busy_seen_q <= 1'b1;

            if (start_wb || start_fill) ram_en_q <= 1'b1;
            else if (done)              ram_en_q <= 1'b0;

            if (accept && !hit) begin
                req_write_q <= bus.cpu_write;
                req_word_q  <= in_word;
                req_idx_q   <= in_idx;
                req_tag_q   <= in_tag;
                req_wdata_q <= bus.cpu_wdata;
                req_wmask_q <= bus.cpu_wmask;
            end

            if (start_wb) begin
                ram_write_q   <= 1'b1;
                ram_addr_q    <= {tag_q[in_idx], in_idx, 3'b000};
                data_to_ram_q <= data_q[in_idx];
            end else if (start_fill) begin
                ram_write_q <= 1'b0;
                ram_addr_q  <= {fill_tag, fill_idx, 3'b000};
            end

            if (hit_acc) begin
                if (bus.cpu_write) dirty_q[in_idx] <= 1'b1;
                else               cpu_rdata_q     <= data_q[in_idx][{in_word, 5'b0} +: 32];
            end

            if (wb_done) dirty_q[req_idx_q] <= 1'b0;

            if (fill_done) begin
                valid_q[req_idx_q] <= 1'b1;
                dirty_q[req_idx_q] <= req_write_q;
                if (!req_write_q) cpu_rdata_q <= bus.data_from_ram[{req_word_q, 5'b0} +: 32];
            end
        end
    end

    // Line data and tags: not reset, only qualified by valid.
    always_ff @(posedge clk) begin
        if (hit_acc && bus.cpu_write) begin
            data_q[in_idx][{in_word, 5'b0} +: 32] <=
                merge_word(data_q[in_idx][{in_word, 5'b0} +: 32], bus.cpu_wdata, bus.cpu_wmask);
        end
        if (fill_done) begin
            data_q[req_idx_q] <= fill_line;
            tag_q[req_idx_q]  <= req_tag_q;
        end
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_write   = ram_write_q;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.data_to_ram = data_to_ram_q;
    assign bus.cpu_rdy     = cpu_rdy_q;
    assign bus.cpu_rdata   = cpu_rdata_q;
endmodule

// File: tb/tb_ddr_line_cache.sv
// Purpose: directed bench for ddr_line_cache with a small DDR controller model.
// Latency: checks hit, clean-miss and dirty-miss completion cycle counts.
// Backpressure: DDR model holds ram_rdy high/low in programmable runs per transaction.
module tb_ddr_line_cache;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ddr_line_cache_if bus();

    ddr_line_cache #(.LINES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DDR model configuration and observations.
    int           rd_pre;
    int           rd_busy;
    int           en_cnt;
    int           nwb;
    int           nfill;
    int           low_run;
    int           last_gap;
    int           unstable;
    logic         prev_en;
    logic [29:0]  wb_addr;
    logic [29:0]  fill_addr;
    logic [255:0] wb_line;
    logic [29:0]  hold_addr;
    logic [255:0] hold_data;

    function automatic logic [255:0] ddr_line(input logic [29:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = (a == 30'h8) ? 32'h1000_0000 : {a[15:0], 16'h0000};
        for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
        return l;
    endfunction

    // DDR controller model: observes each cycle shortly after the edge.
    always begin
        @(posedge clk);
        #2;
        if (bus.ram_en) begin
            if (!prev_en) begin
                last_gap = low_run;
                if (bus.ram_write) begin
                    nwb++;
                    wb_addr = bus.ram_addr;
                    wb_line = bus.data_to_ram;
                end else begin
                    nfill++;
                    fill_addr = bus.ram_addr;
                end
                hold_addr = bus.ram_addr;
                hold_data = bus.data_to_ram;
                en_cnt    = 0;
            end else if (bus.ram_addr !== hold_addr || bus.data_to_ram !== hold_data) begin
                unstable++;
            end
            en_cnt++;
            bus.ram_rdy       = (en_cnt <= rd_pre) ? 1'b1 : (en_cnt <= rd_pre + rd_busy) ? 1'b0 : 1'b1;
            bus.data_from_ram = ddr_line(bus.ram_addr);
            low_run = 0;
        end else begin
            low_run++;
            en_cnt      = 0;
            bus.ram_rdy = 1'b1;
        end
        prev_en = bus.ram_en;
    end

    task automatic cpu_req(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                           input logic [3:0] wm, output logic [31:0] rd, output int cyc);
        logic got;
        @(negedge clk);
        bus.cpu_en    = 1'b1;
        bus.cpu_write = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        bus.cpu_wmask = wm;
        got = 1'b0;
        cyc = 0;
        rd  = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (bus.cpu_rdy) begin
                rd  = bus.cpu_rdata;
                got = 1'b1;
            end
        end
        bus.cpu_en = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL req_timeout addr=%h: no cpu_rdy within 200 cycles", addr);
            cyc = -1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.ram_en !== 1'b0)     begin errors++; $display("FAIL rst_ram_en got %b want 0", bus.ram_en); end
        checks++; if (bus.ram_write !== 1'b0)  begin errors++; $display("FAIL rst_ram_write got %b want 0", bus.ram_write); end
        checks++; if (bus.ram_addr !== 30'h0)  begin errors++; $display("FAIL rst_ram_addr got %h want 0", bus.ram_addr); end
        checks++; if (bus.cpu_rdy !== 1'b0)    begin errors++; $display("FAIL rst_cpu_rdy got %b want 0", bus.cpu_rdy); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h want 0", bus.cpu_rdata); end
        checks++; if (bus.data_to_ram !== 256'h0) begin errors++; $display("FAIL rst_data_to_ram got %h want 0", bus.data_to_ram); end
    endtask

    task automatic test_read_miss;
        logic [31:0] rd;
        int cyc;
        cpu_req(1'b0, 30'h9, 32'h0, 4'h0, rd, cyc);
        checks++; if (nfill !== 1)            begin errors++; $display("FAIL miss_nfill got %0d want 1", nfill); end
        checks++; if (nwb !== 0)              begin errors++; $display("FAIL miss_nwb got %0d want 0", nwb); end
        checks++; if (fill_addr !== 30'h8)    begin errors++; $display("FAIL miss_fill_addr got %h want 8", fill_addr); end
        checks++; if (rd !== 32'h1000_0001)   begin errors++; $display("FAIL miss_rdata got %h want 10000001", rd); end
        checks++; if (cyc !== 3)              begin errors++; $display("FAIL miss_latency got %0d want 3", cyc); end
    endtask

    task automatic test_read_hit;
        logic [31:0] rd;
        int cyc;
        cpu_req(1'b0, 30'hF, 32'h0, 4'h0, rd, cyc);
        checks++; if (nfill !== 1)            begin errors++; $display("FAIL hit_nfill got %0d want 1", nfill); end
        checks++; if (rd !== 32'h1000_0007)   begin errors++; $display("FAIL hit_rdata got %h want 10000007", rd); end
        checks++; if (cyc !== 1)              begin errors++; $display("FAIL hit_latency got %0d want 1", cyc); end
        @(negedge clk);
        checks++; if (bus.cpu_rdy !== 1'b0)   begin errors++; $display("FAIL hit_rdy_pulse got %b want 0", bus.cpu_rdy); end
    endtask

    task automatic test_masked_write;
        logic [31:0] rd;
        int cyc;
        cpu_req(1'b1, 30'h9, 32'hAABB_CCDD, 4'b0101, rd, cyc);
        checks++; if (cyc !== 1)              begin errors++; $display("FAIL wr_latency got %0d want 1", cyc); end
        cpu_req(1'b0, 30'h9, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'h10BB_00DD)   begin errors++; $display("FAIL wr_readback got %h want 10bb00dd", rd); end
        checks++; if (nfill !== 1 || nwb !== 0) begin errors++; $display("FAIL wr_no_ram got fill=%0d wb=%0d want 1/0", nfill, nwb); end
    endtask

    task automatic test_back_to_back;
        logic [3:0] pat;
        @(negedge clk);
        bus.cpu_en    = 1'b1;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 30'hF;
        pat = 4'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat = {pat[2:0], bus.cpu_rdy};
            if (bus.cpu_rdy) begin
                checks++;
                if (bus.cpu_rdata !== 32'h1000_0007) begin errors++; $display("FAIL b2b_rdata got %h want 10000007", bus.cpu_rdata); end
            end
        end
        bus.cpu_en = 1'b0;
        checks++; if (pat !== 4'b1010)        begin errors++; $display("FAIL b2b_rdy_pattern got %b want 1010", pat); end
    endtask

    task automatic test_conflict_wb;
        logic [31:0] rd;
        int cyc;
        cpu_req(1'b0, 30'h29, 32'h0, 4'h0, rd, cyc);
        checks++; if (nwb !== 1)              begin errors++; $display("FAIL wb_count got %0d want 1", nwb); end
        checks++; if (wb_addr !== 30'h8)      begin errors++; $display("FAIL wb_addr got %h want 8", wb_addr); end
        checks++; if (wb_line[63:32] !== 32'h10BB_00DD) begin errors++; $display("FAIL wb_word1 got %h want 10bb00dd", wb_line[63:32]); end
        checks++; if (wb_line[31:0] !== 32'h1000_0000)  begin errors++; $display("FAIL wb_word0 got %h want 10000000", wb_line[31:0]); end
        checks++; if (last_gap !== 1)         begin errors++; $display("FAIL wb_gap got %0d want 1", last_gap); end
        checks++; if (fill_addr !== 30'h28)   begin errors++; $display("FAIL wb_fill_addr got %h want 28", fill_addr); end
        checks++; if (rd !== 32'h0028_0001)   begin errors++; $display("FAIL wb_rdata got %h want 00280001", rd); end
        checks++; if (cyc !== 6)              begin errors++; $display("FAIL wb_latency got %0d want 6", cyc); end
    endtask

    task automatic test_handshake_corner;
        logic [31:0] rd;
        int cyc;
        rd_pre  = 3;
        rd_busy = 5;
        cpu_req(1'b0, 30'h49, 32'h0, 4'h0, rd, cyc);
        rd_pre  = 0;
        rd_busy = 1;
        checks++; if (cyc !== 10)             begin errors++; $display("FAIL hs_latency got %0d want 10", cyc); end
        checks++; if (rd !== 32'h0048_0001)   begin errors++; $display("FAIL hs_rdata got %h want 00480001", rd); end
        checks++; if (nwb !== 1)              begin errors++; $display("FAIL hs_no_wb got %0d want 1", nwb); end
    endtask

    task automatic test_reset_mid_fill;
        logic [31:0] rd;
        logic        seen;
        int          cyc;
        int          fills_before;
        rd_busy = 50;
        @(negedge clk);
        bus.cpu_en    = 1'b1;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = 30'h11;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.ram_en) seen = 1'b1;
        end
        checks++; if (!seen)                  begin errors++; $display("FAIL rmf_fill_start got 0 want 1"); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.ram_en !== 1'b0)    begin errors++; $display("FAIL rmf_ram_en_async got %b want 0", bus.ram_en); end
        checks++; if (bus.ram_addr !== 30'h0) begin errors++; $display("FAIL rmf_ram_addr got %h want 0", bus.ram_addr); end
        bus.cpu_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_busy = 1;
        fills_before = nfill;
        cpu_req(1'b0, 30'h49, 32'h0, 4'h0, rd, cyc);
        checks++; if (nfill !== fills_before + 1) begin errors++; $display("FAIL rmf_miss got fills=%0d want %0d", nfill, fills_before + 1); end
        checks++; if (cyc !== 3)              begin errors++; $display("FAIL rmf_latency got %0d want 3", cyc); end
        checks++; if (rd !== 32'h0048_0001)   begin errors++; $display("FAIL rmf_rdata got %h want 00480001", rd); end
    endtask

    task automatic test_write_allocate;
        logic [31:0] rd;
        int cyc;
        cpu_req(1'b1, 30'h13, 32'hDEAD_BEEF, 4'hF, rd, cyc);
        checks++; if (cyc !== 3)              begin errors++; $display("FAIL wa_latency got %0d want 3", cyc); end
        checks++; if (fill_addr !== 30'h10)   begin errors++; $display("FAIL wa_fill_addr got %h want 10", fill_addr); end
        cpu_req(1'b0, 30'h13, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'hDEAD_BEEF)   begin errors++; $display("FAIL wa_word3 got %h want deadbeef", rd); end
        cpu_req(1'b0, 30'h12, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'h0010_0002)   begin errors++; $display("FAIL wa_word2 got %h want 00100002", rd); end
        checks++; if (unstable !== 0)         begin errors++; $display("FAIL ram_hold_stable got %0d changes want 0", unstable); end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rd_pre   = 0;
        rd_busy  = 1;
        en_cnt   = 0;
        nwb      = 0;
        nfill    = 0;
        low_run  = 100;
        last_gap = -1;
        unstable = 0;
        prev_en  = 1'b0;
        wb_addr  = '0;
        fill_addr = '0;
        wb_line  = '0;
        hold_addr = '0;
        hold_data = '0;
        rst           = 1'b0;
        bus.cpu_en    = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_wmask = '0;
        bus.ram_rdy   = 1'b1;
        bus.data_from_ram = '0;

        test_reset();
        test_read_miss();
        test_read_hit();
        test_masked_write();
        test_back_to_back();
        test_conflict_wb();
        test_handshake_corner();
        test_reset_mid_fill();
        test_write_allocate();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
